// File: rtl/lvds_link_monitor.sv
// LVDS input-link self-test: stimulates one channel group at a time with a tick-rate square
// wave, counts looped-back rising edges per lane and publishes a per-lane pass bit.
module lvds_link_monitor #(
  parameter int NUM_GROUPS   = 2,
  parameter int CH_PER_GROUP = 2,
  parameter int TICK_DIV     = 100,
  parameter int SETTLE_TICKS = 2,
  parameter int WINDOW_TICKS = 32,
  parameter int MIN_EDGES    = 12,
  parameter int MAX_EDGES    = 20,
  parameter int CW           = 8,
  localparam int NL  = NUM_GROUPS * CH_PER_GROUP,
  localparam int AGW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                  clk_100Mz,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NL-1:0]         lane_in,
  output logic [NUM_GROUPS-1:0] stim_out,
  output logic [NL-1:0]         ready_channel,
  output logic [AGW-1:0]        active_group,
  output logic                  busy,
  output logic                  scan_done
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXT = (SETTLE_TICKS > WINDOW_TICKS) ? SETTLE_TICKS : WINDOW_TICKS;
  localparam int TW   = $clog2(MAXT + 1);

  generate
    if (MIN_EDGES > MAX_EDGES || MAX_EDGES >= (1 << CW) - 1 || CW < 1 || CW > 30 ||
        WINDOW_TICKS < 4 || (WINDOW_TICKS % 2) != 0 || SETTLE_TICKS < 1 ||
        TICK_DIV < 2 || NUM_GROUPS < 1 || CH_PER_GROUP < 1) begin : g_bad_params
      $error("lvds_link_monitor: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_EVAL} state_e;
  typedef logic [NUM_GROUPS-1:0][CH_PER_GROUP-1:0] lanes_t;

  state_e                           state_q, state_d;
  logic [PW-1:0]                    presc_q, presc_d;
  logic [TW-1:0]                    tcnt_q, tcnt_d;
  logic                             toggle_q, toggle_d;
  logic [CH_PER_GROUP-1:0][CW-1:0]  cnt_q, cnt_d;
  lanes_t                           ready_q, ready_d;
  logic [AGW-1:0]                   ag_q, ag_d;
  logic [NUM_GROUPS-1:0]            stim_q, stim_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  lanes_t                           sync1_q, sync2_q, sync3_q, edge_g;
  logic                             tick;
  logic                             stim_on;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  assign edge_g  = sync2_q & ~sync3_q;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    toggle_d = toggle_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    ag_d     = ag_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        toggle_d = 1'b0;
        tcnt_d   = '0;
        cnt_d    = '0;
        if (enable) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = '0;
        if (!enable) begin
          state_d  = S_IDLE;
          tcnt_d   = '0;
          toggle_d = 1'b0;
        end else if (tick) begin
          toggle_d = ~toggle_q;
          if (tcnt_q == TW'(SETTLE_TICKS - 1)) begin
            state_d = S_MEASURE;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_MEASURE: begin
        if (!enable) begin
          state_d  = S_IDLE;
          tcnt_d   = '0;
          toggle_d = 1'b0;
          cnt_d    = '0;
        end else begin
          // an edge arriving on the final tick is still counted before EVAL
          for (int unsigned c = 0; c < CH_PER_GROUP; c++) begin
            if (edge_g[ag_q][c] && (cnt_q[c] != '1)) cnt_d[c] = cnt_q[c] + 1'b1;
          end
          if (tick) begin
            toggle_d = ~toggle_q;
            if (tcnt_q == TW'(WINDOW_TICKS - 1)) begin
              state_d = S_EVAL;
              tcnt_d  = '0;
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
        end
      end
      S_EVAL: begin
        for (int unsigned c = 0; c < CH_PER_GROUP; c++) begin
          ready_d[ag_q][c] = (cnt_q[c] >= CW'(MIN_EDGES)) && (cnt_q[c] <= CW'(MAX_EDGES));
        end
        if (ag_q == AGW'(NUM_GROUPS - 1)) begin
          ag_d   = '0;
          done_d = 1'b1;
        end else begin
          ag_d = ag_q + 1'b1;
        end
        cnt_d    = '0;
        tcnt_d   = '0;
        toggle_d = 1'b0;
        state_d  = enable ? S_SETTLE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are derived from next-state values so the registers line up with the FSM
    stim_on = (state_d == S_SETTLE) || (state_d == S_MEASURE);
    busy_d  = (state_d != S_IDLE);
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      stim_d[g] = stim_on && (ag_d == AGW'(g)) && toggle_d;
    end
  end

  always_ff @(posedge clk_100Mz or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      tcnt_q   <= '0;
      toggle_q <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= '0;
      ag_q     <= '0;
      stim_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tcnt_q   <= tcnt_d;
      toggle_q <= toggle_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      ag_q     <= ag_d;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sync1_q  <= lane_in;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
    end
  end

  assign stim_out      = stim_q;
  assign ready_channel = ready_q;
  assign active_group  = ag_q;
  assign busy          = busy_q;
  assign scan_done     = done_q;

endmodule

// File: tb/tb_lvds_link_monitor.sv
// Bench for lvds_link_monitor: lanes are driven by per-lane behaviours (loopback, gated,
// doubled, tied, fast clock) whose edge count per window is predicted arithmetically.
module tb_lvds_link_monitor;

  localparam int NG   = 2;
  localparam int CPG  = 2;
  localparam int NL   = NG * CPG;
  localparam int TD   = 100;
  localparam int ST   = 2;
  localparam int WT   = 32;
  localparam int MINE = 12;
  localparam int MAXE = 20;
  localparam int CW   = 8;

  localparam int M_LOOP = 0;
  localparam int M_GATE = 1;
  localparam int M_DBL  = 2;
  localparam int M_TIE0 = 3;
  localparam int M_TIE1 = 4;
  localparam int M_FAST = 5;

  logic            clk_100Mz = 1'b0;
  logic            rst;
  logic            enable;
  logic [NL-1:0]   lane_in = '0;
  logic [NG-1:0]   stim_out;
  logic [NL-1:0]   ready_channel;
  logic [0:0]      active_group;
  logic            busy;
  logic            scan_done;

  always #5 clk_100Mz = ~clk_100Mz;

  lvds_link_monitor #(
    .NUM_GROUPS(NG), .CH_PER_GROUP(CPG), .TICK_DIV(TD), .SETTLE_TICKS(ST),
    .WINDOW_TICKS(WT), .MIN_EDGES(MINE), .MAX_EDGES(MAXE), .CW(CW)
  ) dut (
    .clk_100Mz(clk_100Mz), .rst(rst), .enable(enable), .lane_in(lane_in),
    .stim_out(stim_out), .ready_channel(ready_channel), .active_group(active_group),
    .busy(busy), .scan_done(scan_done)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // lane behaviour model
  int   mkind [NL];
  int   mk    [NL];
  int   rcnt  [NL];
  int   hcnt  [NL];
  logic prev  [NL];
  int   fdiv = 0;
  logic fast_q = 1'b0;
  logic s, allow;

  always @(posedge clk_100Mz) cyc++;

  // rise #1 of each stimulation falls in SETTLE; gated modes pass rises 2..k+1 (all in MEASURE)
  always @(negedge clk_100Mz) begin
    if (fdiv == 4) begin
      fdiv   = 0;
      fast_q = ~fast_q;
    end else begin
      fdiv++;
    end
    for (int l = 0; l < NL; l++) begin
      s = stim_out[l / CPG];
      if (!busy || int'(active_group) != l / CPG) rcnt[l] = 0;
      else if (s && !prev[l]) begin
        rcnt[l]++;
        hcnt[l] = 0;
      end else if (s) hcnt[l]++;
      prev[l] = s;
      allow = (rcnt[l] >= 2) && (rcnt[l] <= mk[l] + 1);
      case (mkind[l])
        M_LOOP:  lane_in[l] = s;
        M_GATE:  lane_in[l] = s & allow;
        M_DBL:   lane_in[l] = s & allow & !(hcnt[l] >= 20 && hcnt[l] < 40);
        M_TIE1:  lane_in[l] = 1'b1;
        M_FAST:  lane_in[l] = fast_q;
        default: lane_in[l] = 1'b0;
      endcase
    end
  end

  function automatic int edges_of(input int kind, input int k);
    int kk;
    kk = (k > WT / 2) ? WT / 2 : k;
    case (kind)
      M_LOOP:  return WT / 2;
      M_GATE:  return kk;
      M_DBL:   return 2 * kk;
      M_FAST:  return (1 << CW) - 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [NL-1:0] model_ready();
    logic [NL-1:0] r;
    int e;
    for (int l = 0; l < NL; l++) begin
      e = edges_of(mkind[l], mk[l]);
      r[l] = (e >= MINE) && (e <= MAXE);
    end
    return r;
  endfunction

  task automatic set_mode(input int l, input int kind, input int k);
    mkind[l] = kind;
    mk[l]    = k;
  endtask

  task automatic randomize_modes();
    for (int l = 0; l < NL; l++) set_mode(l, int'($urandom_range(0, 5)), int'($urandom_range(6, 16)));
  endtask

  task automatic wait_scan(input string tag);
    int n;
    n = 0;
    @(negedge clk_100Mz);
    while (!scan_done && n < 8000) begin
      @(negedge clk_100Mz);
      n++;
    end
    check({tag, "_seen"}, int'(scan_done), 1);
  endtask

  logic [NL-1:0] exp, exp_prev, exp_now;
  int lat, t_prev, n, pulses;
  logic [NG-1:0] stim_seen;

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    for (int l = 0; l < NL; l++) begin
      set_mode(l, M_LOOP, 0);
      rcnt[l] = 0;
      hcnt[l] = 0;
      prev[l] = 1'b0;
    end
    repeat (3) @(negedge clk_100Mz);
    check("rst_stim", int'(stim_out), 0);
    check("rst_ready", int'(ready_channel), 0);
    check("rst_ag", int'(active_group), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(scan_done), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk_100Mz);
    check("idle_busy", int'(busy), 0);
    check("idle_stim", int'(stim_out), 0);

    // healthy loopback on all lanes
    enable = 1'b1;
    lat = 0;
    while (active_group == 1'b0 && lat < 4000) begin
      @(negedge clk_100Mz);
      lat++;
    end
    check("first_eval_ag", int'(active_group), 1);
    check("first_eval_lat", int'(lat >= (ST + WT - 1) * TD && lat <= (ST + WT + 1) * TD + 2), 1);
    exp = model_ready();
    check("first_eval_g0", int'(ready_channel[1:0]), int'(exp[1:0]));
    check("first_eval_g1_hold", int'(ready_channel[3:2]), 0);
    wait_scan("scan1");
    check("scan1_ready", int'(ready_channel), int'(exp));
    check("scan1_ag", int'(active_group), 0);
    t_prev = cyc;
    @(negedge clk_100Mz);
    check("done_width", int'(scan_done), 0);
    wait_scan("scan2");
    check("scan2_ready", int'(ready_channel), int'(exp));
    check("scan_period", int'((cyc - t_prev) >= 2 * (ST + WT) * TD &&
                              (cyc - t_prev) <= 2 * (ST + WT + 1) * TD), 1);

    // tied lane, saturating fast lane, gated 8 and 12 edges
    set_mode(0, M_GATE, 12);
    set_mode(1, M_TIE0, 0);
    set_mode(2, M_FAST, 0);
    set_mode(3, M_GATE, 8);
    exp = model_ready();
    wait_scan("scan3");
    check("scan3_ready", int'(ready_channel), int'(exp));

    // release tie; 11 edges, 20 edges, 22 edges
    set_mode(0, M_GATE, 11);
    set_mode(1, M_LOOP, 0);
    set_mode(2, M_DBL, 10);
    set_mode(3, M_DBL, 11);
    exp = model_ready();
    wait_scan("scan4");
    check("scan4_ready", int'(ready_channel), int'(exp));

    // abort during group 1 MEASURE
    exp_prev = exp;
    randomize_modes();
    exp_now = model_ready();
    n = 0;
    while (active_group != 1'b1 && n < 8000) begin
      @(negedge clk_100Mz);
      n++;
    end
    check("abort_reach_g1", int'(active_group), 1);
    repeat (1500) @(negedge clk_100Mz);
    enable = 1'b0;
    @(negedge clk_100Mz);
    check("abort_busy", int'(busy), 0);
    check("abort_stim", int'(stim_out), 0);
    check("abort_ag", int'(active_group), 1);
    check("abort_ready_hold", int'(ready_channel), int'({exp_prev[3:2], exp_now[1:0]}));
    pulses = 0;
    stim_seen = '0;
    repeat (500) begin
      @(negedge clk_100Mz);
      pulses += int'(scan_done);
      stim_seen |= stim_out;
    end
    check("abort_no_done", pulses, 0);
    check("abort_stim_quiet", int'(stim_seen), 0);
    enable = 1'b1;
    @(negedge clk_100Mz);
    check("restart_busy", int'(busy), 1);
    check("restart_ag", int'(active_group), 1);
    wait_scan("restart_scan");
    check("restart_ready", int'(ready_channel), int'(exp_now));
    check("restart_ag_wrap", int'(active_group), 0);

    // async reset mid-MEASURE of group 0
    randomize_modes();
    exp_now = model_ready();
    repeat (1000) @(negedge clk_100Mz);
    #3 rst = 1'b1;
    #1;
    check("midrst_stim", int'(stim_out), 0);
    check("midrst_ready", int'(ready_channel), 0);
    check("midrst_ag", int'(active_group), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(scan_done), 0);
    @(negedge clk_100Mz);
    rst = 1'b0;
    @(negedge clk_100Mz);
    check("postrst_busy", int'(busy), 1);
    check("postrst_ag", int'(active_group), 0);
    n = 0;
    while (active_group == 1'b0 && n < 4000) begin
      @(negedge clk_100Mz);
      n++;
    end
    check("postrst_g0_eval", int'(active_group), 1);
    check("postrst_g0_ready", int'(ready_channel), int'({2'b00, exp_now[1:0]}));
    wait_scan("postrst_scan");
    check("postrst_ready", int'(ready_channel), int'(exp_now));

    // randomized lane behaviours
    for (int r = 0; r < 2; r++) begin
      randomize_modes();
      exp = model_ready();
      wait_scan("rand_scan");
      check("rand_ready", int'(ready_channel), int'(exp));
      check("rand_ag", int'(active_group), 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
